// File: rtl/compressor_pkg.sv
// rtl/compressor_pkg.sv - shared sizing helpers for the pipelined 4:2 compressor tree
package compressor_pkg;

  function automatic bit num_ops_legal(input int num_ops);
    return (num_ops == 4) || (num_ops == 8) || (num_ops == 16) || (num_ops == 32);
  endfunction

  // Each level halves the vector count; the tree stops once two vectors remain.
  function automatic int levels_of(input int num_ops);
    return $clog2(num_ops) - 1;
  endfunction

  function automatic int out_width(input int width, input int num_ops);
    return width + $clog2(num_ops);
  endfunction

endpackage

// File: rtl/csa42_row.sv
// rtl/csa42_row.sv - combinational row of 4:2 compressor cells over W bits
module csa42_row #(
  parameter int W = 19
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] c_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] sum_o,
  output logic [W-1:0] carry_o
);

  logic [W-1:0] s1;
  logic [W-1:0] cin;
  logic [W-2:0] cout;
  logic [W-2:0] c;

  // cout depends only on a/b/c, so the cin chain never ripples through a cell.
  assign s1   = a_i ^ b_i ^ c_i;
  assign cout = (a_i[W-2:0] & b_i[W-2:0]) | (a_i[W-2:0] & c_i[W-2:0]) | (b_i[W-2:0] & c_i[W-2:0]);
  assign cin  = {cout, 1'b0};

  assign sum_o = s1 ^ d_i ^ cin;
  assign c     = (s1[W-2:0] & d_i[W-2:0]) | (s1[W-2:0] & cin[W-2:0]) | (d_i[W-2:0] & cin[W-2:0]);

  // Top-bit carries fall off the modulo-2^W result.
  assign carry_o = {c, 1'b0};

endmodule

// File: rtl/compressor_tree_pipe.sv
// rtl/compressor_tree_pipe.sv - pipelined 4:2 compressor tree with valid/ready back-pressure
module compressor_tree_pipe
  import compressor_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int NUM_OPS = 8,
  parameter int OUT_W   = out_width(WIDTH, NUM_OPS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_signed,
  input  logic [NUM_OPS*WIDTH-1:0] in_ops,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_sum,
  output logic [OUT_W-1:0]         out_carry
);

  localparam int LEVELS = levels_of(NUM_OPS);

  if (!num_ops_legal(NUM_OPS)) begin : g_bad_num_ops
    $error("compressor_tree_pipe: NUM_OPS must be 4, 8, 16 or 32");
  end

  logic [NUM_OPS*OUT_W-1:0] ext_ops;

  for (genvar k = 0; k < NUM_OPS; k++) begin : g_ext
    logic [WIDTH-1:0] op;
    assign op = in_ops[k*WIDTH +: WIDTH];
    assign ext_ops[k*OUT_W +: OUT_W] = {{(OUT_W-WIDTH){in_signed & op[WIDTH-1]}}, op};
  end

  // vld[0] is the upstream valid; rdy[LEVELS+1] is the downstream ready.
  logic [LEVELS:0]   vld;
  logic [LEVELS+1:1] rdy;

  assign vld[0]        = in_valid;
  assign rdy[LEVELS+1] = out_ready;

  for (genvar gl = 1; gl <= LEVELS; gl++) begin : g_lvl
    localparam int NIN  = NUM_OPS >> (gl - 1);
    localparam int NOUT = NIN / 2;

    logic [NIN*OUT_W-1:0]  row_in;
    logic [NOUT*OUT_W-1:0] row_out;
    logic [NOUT*OUT_W-1:0] data_d;
    logic [NOUT*OUT_W-1:0] data_q;
    logic                  valid_d;
    logic                  valid_q;

    if (gl == 1) begin : g_src
      assign row_in = ext_ops;
    end else begin : g_src
      assign row_in = g_lvl[gl-1].data_q;
    end

    // Row j folds inputs 4j..4j+3 into outputs 2j (sum) and 2j+1 (carry).
    for (genvar gj = 0; gj < NIN / 4; gj++) begin : g_row
      csa42_row #(
        .W(OUT_W)
      ) u_row (
        .a_i    (row_in[(4*gj+0)*OUT_W +: OUT_W]),
        .b_i    (row_in[(4*gj+1)*OUT_W +: OUT_W]),
        .c_i    (row_in[(4*gj+2)*OUT_W +: OUT_W]),
        .d_i    (row_in[(4*gj+3)*OUT_W +: OUT_W]),
        .sum_o  (row_out[(2*gj+0)*OUT_W +: OUT_W]),
        .carry_o(row_out[(2*gj+1)*OUT_W +: OUT_W])
      );
    end

    assign rdy[gl] = !valid_q || rdy[gl+1];
    assign vld[gl] = valid_q;

    always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (rdy[gl]) begin
        valid_d = vld[gl-1];
        if (vld[gl-1]) begin
          data_d = row_out;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end else begin
        valid_q <= valid_d;
        data_q  <= data_d;
      end
    end
  end

  assign in_ready  = rdy[1];
  assign out_valid = vld[LEVELS];
  assign out_sum   = g_lvl[LEVELS].data_q[OUT_W-1:0];
  assign out_carry = g_lvl[LEVELS].data_q[2*OUT_W-1:OUT_W];

endmodule

// File: tb/tb_compressor_tree_pipe.sv
// tb/tb_compressor_tree_pipe.sv - self-checking bench for compressor_tree_pipe at 4, 8, 16 and 32 operands
module tb_compressor_tree_pipe;

  logic clk;
  logic rst;

  logic         iv   [4];
  logic         isg  [4];
  logic         ordy [4];
  logic [511:0] iops [4];

  logic        ov_a   [4];
  logic        ir_a   [4];
  logic [31:0] pair_a [4];
  logic [31:0] sum_a  [4];
  logic [31:0] car_a  [4];
  int          pend_a [4];

  int total;
  int bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer sum of the extended operands, reduced modulo 2^ow.
  function automatic logic [63:0] ref_sum(input logic [511:0] ops, input logic sg, input int n, input int ow);
    logic [63:0] acc;
    logic [15:0] v;
    acc = '0;
    for (int k = 0; k < n; k++) begin
      v   = ops[k*16 +: 16];
      acc = acc + {{48{sg & v[15]}}, v};
    end
    return acc & ((64'd1 << ow) - 64'd1);
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_cfg
    localparam int NOPS = 4 << g;
    localparam int LV   = $clog2(NOPS) - 1;
    localparam int OW   = 16 + $clog2(NOPS);

    logic          ov;
    logic          ir;
    logic [OW-1:0] os;
    logic [OW-1:0] oc;
    logic [OW-1:0] pr;

    compressor_tree_pipe #(
      .WIDTH  (16),
      .NUM_OPS(NOPS)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (iv[g]),
      .in_ready (ir),
      .in_signed(isg[g]),
      .in_ops   (iops[g][NOPS*16-1:0]),
      .out_valid(ov),
      .out_ready(ordy[g]),
      .out_sum  (os),
      .out_carry(oc)
    );

    assign pr        = os + oc;
    assign ov_a[g]   = ov;
    assign ir_a[g]   = ir;
    assign pair_a[g] = 32'(pr);
    assign sum_a[g]  = 32'(os);
    assign car_a[g]  = 32'(oc);

    logic [63:0]   q_exp [$];
    int            q_t   [$];
    int            cyc   = 0;
    bit            clean = 1'b0;
    bit            held  = 1'b0;
    logic [OW-1:0] hs;
    logic [OW-1:0] hc;
    logic [63:0]   e;
    int            t;

    always @(negedge clk) begin
      cyc++;
      if (rst) begin
        q_exp.delete();
        q_t.delete();
        held  = 1'b0;
        clean = 1'b1;
      end else begin
        if (held) begin
          check($sformatf("n%0d_stall_valid", NOPS), 64'(ov), 64'd1);
          check($sformatf("n%0d_stall_sum", NOPS), 64'(os), 64'(hs));
          check($sformatf("n%0d_stall_carry", NOPS), 64'(oc), 64'(hc));
        end
        held = ov && !ordy[g];
        hs   = os;
        hc   = oc;
        if (!ordy[g]) clean = 1'b0;
        if (ov && ordy[g]) begin
          if (q_exp.size() == 0) begin
            check($sformatf("n%0d_spurious_out", NOPS), 64'd1, 64'd0);
          end else begin
            e = q_exp.pop_front();
            t = q_t.pop_front();
            check($sformatf("n%0d_pair", NOPS), 64'(pr), e);
            if (clean) check($sformatf("n%0d_latency", NOPS), 64'(cyc - t), 64'(LV));
          end
        end
        if (iv[g] && ir) begin
          q_exp.push_back(ref_sum(iops[g], isg[g], NOPS, OW));
          q_t.push_back(cyc);
        end
      end
      pend_a[g] = q_exp.size();
    end
  end

  task automatic run_random(input int g, input int n);
    int acc;
    int budget;
    acc    = 0;
    budget = 0;
    while (acc < n && budget < 40000) begin
      @(posedge clk);
      #1;
      iv[g]  = ($urandom_range(0, 3) != 0);
      isg[g] = 1'($urandom_range(0, 1));
      for (int w = 0; w < 16; w++) iops[g][w*32 +: 32] = $urandom;
      if ($urandom_range(0, 7) == 0) iops[g] = '1;
      ordy[g] = (acc < n / 5) ? 1'b1 : ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (iv[g] && ir_a[g]) acc++;
      budget++;
    end
    check($sformatf("cfg%0d_accept_budget", g), 64'(acc), 64'(n));
    @(posedge clk);
    #1;
    iv[g]   = 1'b0;
    ordy[g] = 1'b1;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int acc;
    int outs;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      iv[i]   = 1'b0;
      isg[i]  = 1'b0;
      ordy[i] = 1'b1;
      iops[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 64'(ov_a[1]), 64'd0);
    check("rst_out_sum", 64'(sum_a[1]), 64'd0);
    check("rst_out_carry", 64'(car_a[1]), 64'd0);
    check("rst_in_ready", 64'(ir_a[1]), 64'd1);

    // All eight operands 0xFFFF, unsigned.
    @(posedge clk);
    #1;
    iv[1]   = 1'b1;
    isg[1]  = 1'b0;
    iops[1] = '0;
    for (int k = 0; k < 8; k++) iops[1][k*16 +: 16] = 16'hFFFF;
    @(posedge clk);
    #1 iv[1] = 1'b0;
    @(negedge clk);
    check("allones_not_yet_valid", 64'(ov_a[1]), 64'd0);
    @(negedge clk);
    check("allones_valid", 64'(ov_a[1]), 64'd1);
    check("allones_pair", 64'(pair_a[1]), 64'h7FFF8);

    // Operand 0 = 0xFFFF, signed then unsigned.
    @(posedge clk);
    #1;
    iv[1]         = 1'b1;
    isg[1]        = 1'b1;
    iops[1]       = '0;
    iops[1][15:0] = 16'hFFFF;
    @(posedge clk);
    #1 isg[1] = 1'b0;
    @(posedge clk);
    #1 iv[1] = 1'b0;
    @(negedge clk);
    check("signed_valid", 64'(ov_a[1]), 64'd1);
    check("signed_pair", 64'(pair_a[1]), 64'h7FFFF);
    @(negedge clk);
    check("unsigned_valid", 64'(ov_a[1]), 64'd1);
    check("unsigned_pair", 64'(pair_a[1]), 64'h0FFFF);

    // Downstream stalled for 5 cycles while inputs keep coming.
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      ordy[1] = 1'b0;
      iv[1]   = 1'b1;
      isg[1]  = 1'($urandom_range(0, 1));
      for (int w = 0; w < 4; w++) iops[1][w*32 +: 32] = $urandom;
      @(negedge clk);
      if (iv[1] && ir_a[1]) acc++;
    end
    check("stall_accepts", 64'(acc), 64'd2);
    check("stall_in_ready_low", 64'(ir_a[1]), 64'd0);
    @(posedge clk);
    #1;
    iv[1]   = 1'b0;
    ordy[1] = 1'b1;
    outs    = 0;
    repeat (6) begin
      @(negedge clk);
      if (ov_a[1] && ordy[1]) outs++;
    end
    check("stall_release_outs", 64'(outs), 64'd2);

    // Reset with two transactions in flight.
    @(posedge clk);
    #1;
    iv[1]  = 1'b1;
    isg[1] = 1'b0;
    for (int w = 0; w < 4; w++) iops[1][w*32 +: 32] = $urandom;
    @(posedge clk);
    #1;
    for (int w = 0; w < 4; w++) iops[1][w*32 +: 32] = $urandom;
    @(posedge clk);
    #1;
    iv[1] = 1'b0;
    rst   = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("flush_out_valid", 64'(ov_a[1]), 64'd0);
    check("flush_out_sum", 64'(sum_a[1]), 64'd0);
    check("flush_out_carry", 64'(car_a[1]), 64'd0);
    outs = 0;
    repeat (4) begin
      @(negedge clk);
      if (ov_a[1]) outs++;
    end
    check("flush_no_stale", 64'(outs), 64'd0);
    @(posedge clk);
    #1;
    iv[1]          = 1'b1;
    isg[1]         = 1'b0;
    iops[1]        = '0;
    iops[1][15:0]  = 16'd3;
    iops[1][31:16] = 16'd5;
    @(posedge clk);
    #1 iv[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("post_reset_valid", 64'(ov_a[1]), 64'd1);
    check("post_reset_pair", 64'(pair_a[1]), 64'd8);

    // Randomised traffic on every operand count.
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    fork
      run_random(0, 10000);
      run_random(1, 10000);
      run_random(2, 10000);
      run_random(3, 10000);
    join
    repeat (20) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) check($sformatf("cfg%0d_drained", i), 64'(pend_a[i]), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
